// File: rtl/mrd_mem_pkt.sv
// Shared types for the DFT memory output path: the buffered source word and the
// admission FSM states.
package mrd_mem_pkt;

   localparam int SRC_EXP_W = 6;
   localparam int SRC_OUT_W = 16;

   typedef struct packed {
      logic                 sop;
      logic                 eop;
      logic [SRC_EXP_W-1:0] exp;
      logic [SRC_OUT_W-1:0] re;
      logic [SRC_OUT_W-1:0] im;
   } src_word_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      DROP
   } src_fsm_t;

endpackage

// File: rtl/mrd_sync_fifo.sv
// Single-clock RAM FIFO with a registered first-word-fall-through output stage.
// o_count covers both the RAM and the output register.
module mrd_sync_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 2048
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic                     o_rd_valid,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_ram_cnt;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             w_pop;
   logic             w_load;

   assign w_pop  = r_out_valid & i_rd_en;
   assign w_load = (r_ram_cnt != '0) & (~r_out_valid | w_pop);

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // The output register refills in the same cycle it is popped, giving one word per clock.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_ram_cnt   <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_load) begin
            r_rd_ptr    <= r_rd_ptr + AW'(1);
            r_out_data  <= r_mem[r_rd_ptr];
            r_out_valid <= 1'b1;
         end else if (w_pop) begin
            r_out_valid <= 1'b0;
         end
         case ({i_wr_en, w_load})
            2'b10:   r_ram_cnt <= r_ram_cnt + (AW+1)'(1);
            2'b01:   r_ram_cnt <= r_ram_cnt - (AW+1)'(1);
            default: r_ram_cnt <= r_ram_cnt;
         endcase
      end
   end

   assign o_rd_valid = r_out_valid;
   assign o_rd_data  = r_out_data;
   assign o_count    = r_ram_cnt + (AW+1)'(r_out_valid);

endmodule

// File: rtl/mrd_source_buf.sv
// Source-phase output stage: rounding shift with saturation, exponent compensation,
// and whole-packet admission into a FIFO feeding a valid/ready stream.
module mrd_source_buf
   import mrd_mem_pkt::*;
#(
   parameter int DEPTH = 2048,
   parameter int IN_W  = 18,
   parameter int OUT_W = SRC_OUT_W,
   parameter int SHIFT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic [IN_W-1:0]      in_real,
   input  logic [IN_W-1:0]      in_imag,
   input  logic [5:0]           in_exp,
   input  logic [11:0]          in_dftpts,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sop,
   output logic                 out_eop,
   output logic [OUT_W-1:0]     out_real,
   output logic [OUT_W-1:0]     out_imag,
   output logic [5:0]           out_exp,
   output logic [15:0]          drop_cnt,
   output logic                 err_len,
   output logic                 err_sop
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = $bits(src_word_t);

   localparam logic [IN_W+1:0]        RND_X2  = (IN_W+2)'(1) << SHIFT;
   localparam logic signed [IN_W:0]   RND     = $signed(RND_X2[IN_W+1:1]);
   localparam logic signed [IN_W:0]   SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0]   SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   // One guard bit keeps x + half-LSB from wrapping before the arithmetic shift.
   function automatic logic [OUT_W-1:0] f_scale(input logic [IN_W-1:0] x);
      logic signed [IN_W:0] v;
      v = $signed({x[IN_W-1], x}) + RND;
      v = v >>> SHIFT;
      if (v > SAT_MAX) begin
         return SAT_MAX[OUT_W-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[OUT_W-1:0];
      end
      return v[OUT_W-1:0];
   endfunction

   src_fsm_t             r_state;
   logic [11:0]          r_len;
   logic [11:0]          r_cnt;
   logic [SRC_EXP_W-1:0] r_exp;
   logic [15:0]          r_drop_cnt;
   logic                 r_err_len;
   logic                 r_err_sop;
   logic                 r_pipe_valid;
   src_word_t            r_pipe_word;

   logic [CW-1:0]        w_fifo_count;
   logic                 w_rd_valid;
   logic [WW-1:0]        w_rd_data;
   src_word_t            w_out_word;
   src_word_t            w_word;
   logic [6:0]           w_exp_sum;
   logic [SRC_EXP_W-1:0] w_exp_sat;
   logic                 w_idle;
   logic                 w_sop_start;
   logic                 w_zero_len;
   logic                 w_admit;
   logic                 w_last;
   logic                 w_wr;
   logic                 w_pkt_sample;
   logic [11:0]          w_len_cur;
   logic [11:0]          w_cnt_cur;
   logic [15:0]          w_occ;
   logic [15:0]          w_free;

   assign w_exp_sum = {1'b0, in_exp} + 7'(SHIFT);
   assign w_exp_sat = w_exp_sum[6] ? 6'h3F : w_exp_sum[5:0];

   // The word sitting in the scaler register is counted so admission never overcommits.
   assign w_occ  = 16'(w_fifo_count) + 16'(r_pipe_valid);
   assign w_free = 16'(DEPTH) - w_occ;

   assign w_idle       = (r_state == IDLE);
   assign w_sop_start  = w_idle & in_valid & in_sop;
   assign w_zero_len   = (in_dftpts == 12'd0);
   assign w_admit      = w_sop_start & ~w_zero_len & (w_free >= 16'(in_dftpts));
   assign w_len_cur    = w_idle ? in_dftpts : r_len;
   assign w_cnt_cur    = w_idle ? 12'd0 : r_cnt;
   assign w_last       = (w_cnt_cur == w_len_cur - 12'd1);
   assign w_wr         = in_valid & ((w_idle & w_admit) | (r_state == ACCEPT));
   assign w_pkt_sample = in_valid & ((w_sop_start & ~w_zero_len) | ~w_idle);

   always_comb begin
      w_word     = '0;
      w_word.sop = (w_cnt_cur == 12'd0);
      w_word.eop = w_last;
      w_word.exp = w_idle ? w_exp_sat : r_exp;
      w_word.re  = f_scale(in_real);
      w_word.im  = f_scale(in_imag);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_len        <= '0;
         r_cnt        <= '0;
         r_exp        <= '0;
         r_drop_cnt   <= '0;
         r_err_len    <= 1'b0;
         r_err_sop    <= 1'b0;
         r_pipe_valid <= 1'b0;
         r_pipe_word  <= '0;
      end else begin
         r_pipe_valid <= w_wr;
         r_pipe_word  <= w_word;
         if (in_valid & in_sop & ~w_idle) begin
            r_err_sop <= 1'b1;
         end
         if (w_pkt_sample & (in_eop != w_last)) begin
            r_err_len <= 1'b1;
         end
         // Framing follows the latched length; in_eop and stray sops never end a packet.
         case (r_state)
            IDLE: begin
               if (w_sop_start) begin
                  r_len <= in_dftpts;
                  r_exp <= w_exp_sat;
                  r_cnt <= 12'd1;
                  if (~w_admit && r_drop_cnt != 16'hFFFF) begin
                     r_drop_cnt <= r_drop_cnt + 16'd1;
                  end
                  if (w_zero_len | w_last) begin
                     r_state <= IDLE;
                  end else if (w_admit) begin
                     r_state <= ACCEPT;
                  end else begin
                     r_state <= DROP;
                  end
               end
            end
            ACCEPT, DROP: begin
               if (in_valid) begin
                  if (w_last) begin
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 12'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mrd_sync_fifo #(
      .WIDTH (WW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_en    (r_pipe_valid),
      .i_wr_data  (r_pipe_word),
      .i_rd_en    (out_ready),
      .o_rd_valid (w_rd_valid),
      .o_rd_data  (w_rd_data),
      .o_count    (w_fifo_count)
   );

   assign w_out_word = w_rd_data;
   assign out_valid  = w_rd_valid;
   assign out_sop    = w_out_word.sop;
   assign out_eop    = w_out_word.eop;
   assign out_exp    = w_out_word.exp;
   assign out_real   = w_out_word.re;
   assign out_imag   = w_out_word.im;
   assign drop_cnt   = r_drop_cnt;
   assign err_len    = r_err_len;
   assign err_sop    = r_err_sop;

endmodule
